stream_capture_serializer: RTL and testbench

STREAM_CAPTURE_SERIALIZER -- requirements
Module: stream_capture_serializer

---
 rtl/stream_capture_serializer.sv | 169 ++++++++++++++++
 tb/tb_stream_capture_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_capture_serializer.sv
// Per-channel capture FIFOs drained round-robin into OUT_W-wide frames (header beat + payload beats).
// Optional parity beat per frame when CAPTURE_PARITY_EN is defined.
module stream_capture_serializer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int OUT_W      = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [NUM_CH-1:0]        overflow,
  output logic [OUT_W-1:0]         data_out,
  output logic                     data_valid,
  output logic                     frame_start,
  output logic                     probe_out
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NBEATS = DATA_W / OUT_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

`ifdef CAPTURE_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;
`endif

  logic [DATA_W-1:0] r_mem  [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr [NUM_CH];
  logic [PTR_W-1:0]  r_rptr [NUM_CH];
  logic [PTR_W:0]    r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_overflow;
  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_gch, r_rr;
  logic [DATA_W-1:0] r_shift;
  logic [BEAT_W-1:0] r_beat;
  logic              r_probe;
`ifdef CAPTURE_PARITY_EN
  logic              r_par;
`endif

  logic [NUM_CH-1:0] w_push, w_pop;
  logic [CH_W-1:0]   w_gch, w_cand;
  logic              w_any, w_pop_en, w_last_beat, w_frame_done;
  logic [DATA_W-1:0] w_head;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_full[i] = (r_cnt[i] == (PTR_W+1)'(FIFO_DEPTH));
      w_push[i]  = ch_write[i] & ~ch_full[i];
      w_pop[i]   = w_pop_en && (w_gch == CH_W'(i));
    end
  end

  assign overflow  = r_overflow;
  assign probe_out = r_probe;
  assign w_head    = r_mem[w_gch][r_rptr[w_gch]];

  // Scan from the farthest offset down so the nearest non-empty channel after r_rr wins.
  always_comb begin
    w_any  = 1'b0;
    w_gch  = '0;
    w_cand = '0;
    for (int unsigned k = NUM_CH; k > 0; k--) begin
      w_cand = CH_W'((32'(r_rr) + k - 1) % NUM_CH);
      if (r_cnt[w_cand] != '0) begin
        w_any = 1'b1;
        w_gch = w_cand;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    data_out     = '0;
    data_valid   = 1'b0;
    frame_start  = 1'b0;
    w_pop_en     = 1'b0;
    w_frame_done = 1'b0;
    w_last_beat  = (r_beat == BEAT_W'(NBEATS - 1));
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_pop_en    = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        data_out    = OUT_W'(r_gch);
        data_valid  = 1'b1;
        frame_start = 1'b1;
        w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        data_out   = r_shift[DATA_W-1 -: OUT_W];
        data_valid = 1'b1;
        if (w_last_beat) begin
`ifdef CAPTURE_PARITY_EN
          w_state_nxt  = S_PARITY;
`else
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
`endif
        end
      end
`ifdef CAPTURE_PARITY_EN
      S_PARITY: begin
        data_out     = OUT_W'(r_par);
        data_valid   = 1'b1;
        w_state_nxt  = S_IDLE;
        w_frame_done = 1'b1;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (w_push[i]) r_mem[i][r_wptr[i]] <= ch_din[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_overflow <= '0;
      r_gch      <= '0;
      r_rr       <= '0;
      r_shift    <= '0;
      r_beat     <= '0;
      r_probe    <= 1'b0;
`ifdef CAPTURE_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + (PTR_W+1)'(w_push[i]) - (PTR_W+1)'(w_pop[i]);
        if (ch_write[i] && ch_full[i]) r_overflow[i] <= 1'b1;
      end
      if (w_pop_en) begin
        r_shift <= w_head;
        r_gch   <= w_gch;
        r_rr    <= (w_gch == CH_W'(NUM_CH - 1)) ? '0 : w_gch + 1'b1;
        r_beat  <= '0;
`ifdef CAPTURE_PARITY_EN
        r_par   <= ^w_head;
`endif
      end else if (r_state == S_PAYLOAD) begin
        r_shift <= r_shift << OUT_W;
        r_beat  <= r_beat + 1'b1;
      end
      if (w_frame_done) r_probe <= ~r_probe;
    end
  end
endmodule

// File: tb/tb_stream_capture_serializer.sv
// Bench for stream_capture_serializer: queue-based frame model plus directed scenarios and random traffic.
module tb_stream_capture_serializer;
  localparam int NUM_CH = 4, DATA_W = 32, FIFO_DEPTH = 16, OUT_W = 4;
  localparam int NB = DATA_W / OUT_W;
`ifdef CAPTURE_PARITY_EN
  localparam int FLEN = NB + 2;
`else
  localparam int FLEN = NB + 1;
`endif

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*DATA_W-1:0] ch_din;
  logic [NUM_CH-1:0]        ch_full, overflow;
  logic [OUT_W-1:0]         data_out;
  logic                     data_valid, frame_start, probe_out;

  always #5 ap_clk = ~ap_clk;

  stream_capture_serializer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OUT_W(OUT_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ch_write(ch_write), .ch_din(ch_din),
    .ch_full(ch_full), .overflow(overflow), .data_out(data_out),
    .data_valid(data_valid), .frame_start(frame_start), .probe_out(probe_out));

  typedef struct {int ch; logic [DATA_W-1:0] w;} entry_t;
  typedef struct {logic [OUT_W-1:0] d; logic fs; logic last;} beat_t;
  typedef struct {logic [OUT_W-1:0] d; logic fs; int cyc;} obs_t;

  entry_t            mfifo[$];
  beat_t             mbeats[$];
  obs_t              obs[$];
  int unsigned       m_rr;
  logic [NUM_CH-1:0] m_ovf;
  logic              m_probe;
  int                checks = 0, errors = 0, cyc = 0;
  logic              saw_full2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int occ(int c);
    int n = 0;
    foreach (mfifo[k]) if (mfifo[k].ch == c) n++;
    return n;
  endfunction

  function automatic void model_reset();
    mfifo.delete();
    mbeats.delete();
    m_rr    = 0;
    m_ovf   = '0;
    m_probe = 1'b0;
  endfunction

  // A frame is the channel number, then the word's slices MSB-first, then optionally its parity.
  function automatic void add_frame(int c, logic [DATA_W-1:0] w);
    beat_t b;
    b.d = OUT_W'(c); b.fs = 1'b1; b.last = 1'b0;
    mbeats.push_back(b);
    for (int j = NB - 1; j >= 0; j--) begin
      b.d = OUT_W'(w >> (OUT_W * j)); b.fs = 1'b0; b.last = 1'b0;
`ifndef CAPTURE_PARITY_EN
      b.last = (j == 0);
`endif
      mbeats.push_back(b);
    end
`ifdef CAPTURE_PARITY_EN
    b.d = OUT_W'(^w); b.fs = 1'b0; b.last = 1'b1;
    mbeats.push_back(b);
`endif
  endfunction

  function automatic void pop_head(int c);
    int idx = -1;
    foreach (mfifo[k]) if (idx < 0 && mfifo[k].ch == c) idx = k;
    add_frame(c, mfifo[idx].w);
    mfifo.delete(idx);
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] put(int c, logic [DATA_W-1:0] w);
    logic [NUM_CH*DATA_W-1:0] v = '0;
    v[c*DATA_W +: DATA_W] = w;
    return v;
  endfunction

  task automatic step(input logic rst, input logic [NUM_CH-1:0] wr, input logic [NUM_CH*DATA_W-1:0] din);
    beat_t             b;
    logic              ev, found;
    logic [NUM_CH-1:0] full0;
    int                c;
    @(negedge ap_clk);
    ap_rst_n = rst; ch_write = wr; ch_din = din;
    #1;
    ev = (mbeats.size() > 0);
    b.d = '0; b.fs = 1'b0; b.last = 1'b0;
    if (ev) b = mbeats.pop_front();
    for (int k = 0; k < NUM_CH; k++) full0[k] = (occ(k) == FIFO_DEPTH);
    check("data_valid", 32'(data_valid), 32'(ev));
    check("data_out", 32'(data_out), 32'(b.d));
    check("frame_start", 32'(frame_start), 32'(b.fs));
    check("probe_out", 32'(probe_out), 32'(m_probe));
    check("ch_full", 32'(ch_full), 32'(full0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (data_valid === 1'b1) obs.push_back('{data_out, frame_start, cyc});
    if (ch_full[2] === 1'b1) saw_full2 = 1'b1;
    if (ev && b.last) m_probe = ~m_probe;
    if (!rst) model_reset();
    else begin
      found = 1'b0;
      if (!ev) begin
        for (int k = 0; k < NUM_CH; k++) begin
          c = (int'(m_rr) + k) % NUM_CH;
          if (!found && occ(c) > 0) begin
            found = 1'b1;
            pop_head(c);
            m_rr = (c + 1) % NUM_CH;
          end
        end
      end
      for (int k = 0; k < NUM_CH; k++)
        if (wr[k]) begin
          if (full0[k]) m_ovf[k] = 1'b1;
          else mfifo.push_back('{k, din[k*DATA_W +: DATA_W]});
        end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0);
  endtask

  initial begin
    int w0, nfr;
    logic [DATA_W-1:0] word, ref_w;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH*DATA_W-1:0] din;
    int dens;

    ap_rst_n = 1'b0; ch_write = '0; ch_din = '0;
    repeat (3) @(posedge ap_clk);
    model_reset();
    idle(2);

    // Single word on ch0: header 0, nibbles D E A D B E E F, latency 2.
    obs.delete(); w0 = cyc;
    step(1'b1, 4'b0001, put(0, 32'hDEADBEEF));
    idle(12);
    check("f0_len", obs.size(), NB + 1);
    if (obs.size() >= NB + 1) begin
      ref_w = 32'hDEADBEEF;
      check("f0_latency", obs[0].cyc - w0, 2);
      check("f0_hdr", {obs[0].fs, obs[0].d}, {1'b1, 4'h0});
      for (int j = 1; j <= NB; j++)
        check("f0_payload", obs[j].d, ref_w[DATA_W-1-OUT_W*(j-1) -: OUT_W]);
    end
    check("f0_probe", probe_out, 1);

    // Simultaneous ch1/ch3, then all four pending: ch0 granted next.
    obs.delete();
    step(1'b1, 4'b1010, put(1, 32'h11111111) | put(3, 32'h33333333));
    idle(2 * (FLEN + 1) + 4);
    check("rr_len", obs.size(), 2 * FLEN);
    if (obs.size() >= 2 * FLEN) begin
      check("rr_first", {obs[0].fs, obs[0].d}, {1'b1, 4'h1});
      check("rr_second", {obs[FLEN].fs, obs[FLEN].d}, {1'b1, 4'h3});
    end
    obs.delete();
    step(1'b1, 4'b1111, put(0, 32'hA0A0A0A0) | put(1, 32'hA1A1A1A1) | put(2, 32'hA2A2A2A2) | put(3, 32'hA3A3A3A3));
    idle(4 * (FLEN + 1) + 4);
    check("rr_all_len", obs.size(), 4 * FLEN);
    if (obs.size() >= 4 * FLEN)
      for (int f = 0; f < 4; f++) check("rr_all_order", obs[f*FLEN].d, (f % NUM_CH));

    // ch2 burst of 19 back-to-back writes: fills while two frames drain, last write dropped.
    obs.delete();
    for (int k = 0; k < 19; k++) step(1'b1, 4'b0100, put(2, 32'hC2000000 + k));
    idle(19 * (FLEN + 1) + 10);
    check("burst_full_seen", saw_full2, 1);
    check("burst_ovf_sticky", overflow, 4'b0100);
    nfr = obs.size() / FLEN;
    check("burst_frames", obs.size(), 18 * FLEN);
    for (int f = 0; f < nfr && f < 18; f++) begin
      word = '0;
      for (int j = 1; j <= NB; j++) word = (word << OUT_W) | DATA_W'(obs[f*FLEN + j].d);
      check("burst_hdr", obs[f*FLEN].d, 2);
      check("burst_order", word, 32'hC2000000 + f);
    end

    // Reset on the 4th payload beat abandons the frame.
    obs.delete();
    step(1'b1, 4'b0001, put(0, 32'hCAFE1234));
    idle(5);
    step(1'b0, '0, '0);
    check("rst_beats_before", obs.size(), 5);
    if (obs.size() >= 5) check("rst_4th_beat", obs[4].d, 4'hE);
    obs.delete();
    idle(FLEN + 6);
    check("rst_no_resume", obs.size(), 0);
    check("rst_outputs", {data_out, data_valid, frame_start, probe_out, ch_full, overflow}, '0);

`ifdef CAPTURE_PARITY_EN
    obs.delete();
    step(1'b1, 4'b0001, put(0, 32'h00000001));
    idle(FLEN + 4);
    check("par1_len", obs.size(), NB + 2);
    if (obs.size() >= NB + 2) check("par1_last", obs[NB+1].d, 1);
    obs.delete();
    step(1'b1, 4'b0001, put(0, 32'h00000003));
    idle(FLEN + 4);
    check("par3_len", obs.size(), NB + 2);
    if (obs.size() >= NB + 2) check("par3_last", obs[NB+1].d, 0);
`endif

    // Random traffic: light, heavy (overflows), medium; rare resets.
    for (int t = 0; t < 3000; t++) begin
      dens = (t < 1000) ? 5 : (t < 2000) ? 40 : 10;
      for (int c = 0; c < NUM_CH; c++) begin
        wr[c] = ($urandom_range(0, 99) < dens);
        din[c*DATA_W +: DATA_W] = $urandom();
      end
      step(($urandom_range(0, 999) != 0), wr, din);
    end
    idle(NUM_CH * FIFO_DEPTH * (FLEN + 1) + 10);
    check("drain_empty", ch_full, '0);
    check("drain_idle", data_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
